// File: rtl/mips_core_pkg.sv
// Shared core types: PC width, branch direction, and the per-branch record
// kept between decode-time prediction and execute-time resolution.
package mips_core_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    BranchOutcome          prediction;
    logic [ADDR_WIDTH-1:0] recovery_target;
  } branch_entry_t;

endpackage

// File: rtl/branch_resolution_queue_fifo.sv
// In-order circular buffer of branch records; head entry readable combinationally.
// Clear dominates push/pop; caller guarantees push only when a slot frees up.
module branch_entry_fifo
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  branch_entry_t              push_data,
  input  logic                       pop,
  input  logic                       clear,
  output branch_entry_t              head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  branch_entry_t mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_data;
  end

  assign head_data = mem[head];
  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;

endmodule

// File: rtl/branch_resolution_queue.sv
// Tracks in-flight conditional-branch predictions; feedback and redirect appear
// one cycle after resolve. Decode must stall on o_full; overflow/underflow set o_error.
module branch_resolution_queue
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = mips_core_pkg::ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_req_valid,
  input  logic [ADDR_WIDTH-1:0]  i_req_pc,
  input  BranchOutcome           i_req_prediction,
  input  logic [ADDR_WIDTH-1:0]  i_req_recovery_target,
  input  logic                   i_res_valid,
  input  BranchOutcome           i_res_outcome,
  input  logic                   i_flush,
  output logic                   o_fb_valid,
  output logic [ADDR_WIDTH-1:0]  o_fb_pc,
  output BranchOutcome           o_fb_prediction,
  output BranchOutcome           o_fb_outcome,
  output logic                   o_mispredict,
  output logic [ADDR_WIDTH-1:0]  o_recovery_target,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_error
);

  branch_entry_t head_entry;
  branch_entry_t new_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_ok;
  logic          mispredict_now;
  logic          push_ok;
  logic          clear;
  logic          proto_err;

  assign new_entry = '{pc: i_req_pc, prediction: i_req_prediction,
                       recovery_target: i_req_recovery_target};

  assign pop_ok         = i_res_valid && !fifo_empty;
  // A flush already redirects the pipeline, so it masks the mispredict redirect.
  assign mispredict_now = pop_ok && (head_entry.prediction != i_res_outcome) && !i_flush;
  assign clear          = i_flush || mispredict_now;
  assign push_ok        = i_req_valid && (!fifo_full || pop_ok) && !clear;
  assign proto_err      = (i_req_valid && fifo_full && !pop_ok) ||
                          (i_res_valid && fifo_empty);

  branch_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data (new_entry),
    .pop       (pop_ok),
    .clear     (clear),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fb_valid        <= 1'b0;
      o_fb_pc           <= '0;
      o_fb_prediction   <= NOT_TAKEN;
      o_fb_outcome      <= NOT_TAKEN;
      o_mispredict      <= 1'b0;
      o_recovery_target <= '0;
      o_error           <= 1'b0;
    end else begin
      o_fb_valid   <= pop_ok;
      o_mispredict <= mispredict_now;
      if (pop_ok) begin
        o_fb_pc         <= head_entry.pc;
        o_fb_prediction <= head_entry.prediction;
        o_fb_outcome    <= i_res_outcome;
      end
      if (mispredict_now) o_recovery_target <= head_entry.recovery_target;
      if (proto_err)      o_error <= 1'b1;
    end
  end

  assign o_full  = fifo_full;
  assign o_empty = fifo_empty;

endmodule
